// File: rtl/pwm_multichannel_if.sv
// Write-only register bus for pwm_multichannel: one write per cycle, strobed by wr_en.
interface pwm_multichannel_if;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;

  modport master (output wr_en, output wr_addr, output wr_data);
  modport slave  (input  wr_en, input  wr_addr, input  wr_data);
endinterface

// File: rtl/pwm_multichannel.sv
// Multichannel PWM: shared prescaler and edge/center counter, per-channel duty compare,
// with duty/prescale/mode taking effect only at period boundaries.
module pwm_multichannel #(
  parameter int NUM_CH = 16,
  parameter int RES    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  pwm_multichannel_if.slave bus,
  output logic [NUM_CH-1:0] out,
  output logic              period_start
);

  typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_e;

  localparam logic [RES-1:0] CNT_MAX = {RES{1'b1}};
  localparam logic [RES-1:0] CNT_ONE = {{(RES-1){1'b0}}, 1'b1};

  logic [NUM_CH-1:0]          en_out_q, en_out_d;
  logic [NUM_CH-1:0]          en_pwm_q, en_pwm_d;
  logic [7:0]                 prescale_sh_q, prescale_sh_d;
  logic [7:0]                 prescale_act_q, prescale_act_d;
  logic                       mode_sh_q, mode_sh_d;
  logic                       mode_act_q, mode_act_d;
  logic [NUM_CH-1:0][RES-1:0] duty_sh_q, duty_sh_d;
  logic [NUM_CH-1:0][RES-1:0] duty_act_q, duty_act_d;
  logic [7:0]                 presc_cnt_q, presc_cnt_d;
  logic [RES-1:0]             cnt_q, cnt_d;
  dir_e                       dir_q, dir_d;
  logic [NUM_CH-1:0]          out_q, out_d;
  logic                       period_start_q, period_start_d;
  logic [NUM_CH-1:0]          pwm;
  logic                       tick;
  logic                       boundary;

  // Register bank decode; channel bits and duty slots beyond NUM_CH are simply never written.
  always_comb begin
    en_out_d      = en_out_q;
    en_pwm_d      = en_pwm_q;
    prescale_sh_d = prescale_sh_q;
    mode_sh_d     = mode_sh_q;
    duty_sh_d     = duty_sh_q;
    if (bus.wr_en) begin
      for (int b = 0; b < NUM_CH; b++) begin
        if (b < 8) begin
          if (bus.wr_addr == 8'h00) en_out_d[b] = bus.wr_data[b % 8];
          if (bus.wr_addr == 8'h02) en_pwm_d[b] = bus.wr_data[b % 8];
        end else begin
          if (bus.wr_addr == 8'h01) en_out_d[b] = bus.wr_data[b % 8];
          if (bus.wr_addr == 8'h03) en_pwm_d[b] = bus.wr_data[b % 8];
        end
      end
      if (bus.wr_addr == 8'h04) prescale_sh_d = bus.wr_data;
      if (bus.wr_addr == 8'h05) mode_sh_d = bus.wr_data[0];
      for (int i = 0; i < NUM_CH; i++) begin
        if (bus.wr_addr == 8'(8'h10 + i)) duty_sh_d[i] = bus.wr_data[RES-1:0];
      end
    end
  end

  // Center mode reverses at the top and ends the period on the tick that returns to zero.
  always_comb begin
    tick           = (presc_cnt_q == prescale_act_q);
    presc_cnt_d    = tick ? 8'd0 : presc_cnt_q + 8'd1;
    cnt_d          = cnt_q;
    dir_d          = dir_q;
    boundary       = 1'b0;
    prescale_act_d = prescale_act_q;
    mode_act_d     = mode_act_q;
    duty_act_d     = duty_act_q;
    if (tick) begin
      if (!mode_act_q) begin
        cnt_d    = cnt_q + CNT_ONE;
        boundary = (cnt_q == CNT_MAX);
      end else if (dir_q == DIR_UP) begin
        if (cnt_q == CNT_MAX) begin
          cnt_d = cnt_q - CNT_ONE;
          dir_d = DIR_DOWN;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end else begin
        cnt_d    = cnt_q - CNT_ONE;
        boundary = (cnt_q == CNT_ONE);
      end
    end
    if (boundary) begin
      cnt_d          = '0;
      dir_d          = DIR_UP;
      prescale_act_d = prescale_sh_q;
      mode_act_d     = mode_sh_q;
      duty_act_d     = duty_sh_q;
    end
  end

  always_comb begin
    pwm   = '0;
    out_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      pwm[i]   = (duty_act_q[i] == CNT_MAX) || (cnt_q < duty_act_q[i]);
      out_d[i] = en_out_q[i] & (~en_pwm_q[i] | pwm[i]);
    end
    period_start_d = boundary;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_out_q       <= '0;
      en_pwm_q       <= '0;
      prescale_sh_q  <= '0;
      prescale_act_q <= '0;
      mode_sh_q      <= 1'b0;
      mode_act_q     <= 1'b0;
      duty_sh_q      <= '0;
      duty_act_q     <= '0;
      presc_cnt_q    <= '0;
      cnt_q          <= '0;
      dir_q          <= DIR_UP;
      out_q          <= '0;
      period_start_q <= 1'b0;
    end else begin
      en_out_q       <= en_out_d;
      en_pwm_q       <= en_pwm_d;
      prescale_sh_q  <= prescale_sh_d;
      prescale_act_q <= prescale_act_d;
      mode_sh_q      <= mode_sh_d;
      mode_act_q     <= mode_act_d;
      duty_sh_q      <= duty_sh_d;
      duty_act_q     <= duty_act_d;
      presc_cnt_q    <= presc_cnt_d;
      cnt_q          <= cnt_d;
      dir_q          <= dir_d;
      out_q          <= out_d;
      period_start_q <= period_start_d;
    end
  end

  assign out          = out_q;
  assign period_start = period_start_q;

endmodule

// File: tb/tb_pwm_multichannel.sv
// Self-checking bench for pwm_multichannel: directed period measurements plus a
// randomized register-write run checked every cycle against a phase-based model.
module tb_pwm_multichannel;
  localparam int NUM_CH = 12;
  localparam int RES    = 8;
  localparam int CMAX   = (1 << RES) - 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NUM_CH-1:0] out;
  logic              period_start;

  pwm_multichannel_if bus_if ();

  pwm_multichannel #(.NUM_CH(NUM_CH), .RES(RES)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus_if),
    .out          (out),
    .period_start (period_start)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model: position within the period as a tick index, from which the counter value follows.
  logic [15:0] m_en_out, m_en_pwm, m_out;
  logic        m_ps;
  int          m_presc_sh, m_presc_act, m_mode_sh, m_mode_act;
  int          m_duty_sh [16];
  int          m_duty_act[16];
  int          m_pcnt, m_phase;

  function automatic int period_len(input int mode);
    return (mode != 0) ? 2 * CMAX : CMAX + 1;
  endfunction

  function automatic bit boundary_next();
    return (m_pcnt == m_presc_act) && (m_phase + 1 == period_len(m_mode_act));
  endfunction

  task automatic model_reset();
    m_en_out = '0; m_en_pwm = '0; m_out = '0; m_ps = 1'b0;
    m_presc_sh = 0; m_presc_act = 0; m_mode_sh = 0; m_mode_act = 0;
    m_pcnt = 0; m_phase = 0;
    for (int i = 0; i < 16; i++) begin
      m_duty_sh[i]  = 0;
      m_duty_act[i] = 0;
    end
  endtask

  task automatic model_edge();
    int c, a, d;
    bit pwm, bnd;
    logic [15:0] nout;
    c = (m_mode_act != 0 && m_phase > CMAX) ? 2 * CMAX - m_phase : m_phase;
    for (int i = 0; i < 16; i++) begin
      pwm     = (m_duty_act[i] == CMAX) ? 1'b1 : (c < m_duty_act[i]);
      nout[i] = m_en_out[i] && (!m_en_pwm[i] || pwm);
    end
    bnd = 1'b0;
    if (m_pcnt == m_presc_act) begin
      m_pcnt = 0;
      if (m_phase + 1 == period_len(m_mode_act)) begin
        bnd         = 1'b1;
        m_phase     = 0;
        m_presc_act = m_presc_sh;
        m_mode_act  = m_mode_sh;
        for (int i = 0; i < 16; i++) m_duty_act[i] = m_duty_sh[i];
      end else begin
        m_phase++;
      end
    end else begin
      m_pcnt++;
    end
    m_ps  = bnd;
    m_out = nout;
    if (bus_if.wr_en === 1'b1) begin
      a = int'(bus_if.wr_addr);
      d = int'(bus_if.wr_data);
      case (a)
        0: m_en_out[7:0]  = bus_if.wr_data;
        1: m_en_out[15:8] = bus_if.wr_data;
        2: m_en_pwm[7:0]  = bus_if.wr_data;
        3: m_en_pwm[15:8] = bus_if.wr_data;
        4: m_presc_sh     = d;
        5: m_mode_sh      = d % 2;
        default: if (a >= 16 && a < 16 + NUM_CH) m_duty_sh[a - 16] = d % (CMAX + 1);
      endcase
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic write_reg(input logic [7:0] a, input logic [7:0] d);
    bus_if.wr_en   = 1'b1;
    bus_if.wr_addr = a;
    bus_if.wr_data = d;
    cycle();
    bus_if.wr_en   = 1'b0;
  endtask

  // Runs up to and including the next period_start cycle, gathering out[0] statistics.
  task automatic run_period(input int limit, output int cyc, output int highs,
                            output int disagree, output int ps_seen);
    cyc = 0; highs = 0; disagree = 0;
    do begin
      cycle();
      cyc++;
      if (out[0]) highs++;
      if (out !== m_out[NUM_CH-1:0] || period_start !== m_ps) disagree++;
    end while (period_start !== 1'b1 && cyc < limit);
    ps_seen = (period_start === 1'b1) ? 1 : 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus_if.wr_en = 1'b0; bus_if.wr_addr = '0; bus_if.wr_data = '0;
    model_reset();
    repeat (3) begin
      @(posedge clk); #1;
      checks++; if (out !== '0) begin errors++; $display("[TB] FAIL reset_out: out=%h expected 000", out); end
      checks++; if (period_start !== 1'b0) begin errors++; $display("[TB] FAIL reset_ps: period_start=%b expected 0", period_start); end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_enable_out();
    write_reg(8'h00, 8'h01);
    checks++; if (out !== 12'h000) begin errors++; $display("[TB] FAIL en_out_early: out=%h expected 000", out); end
    cycle();
    checks++; if (out !== 12'h001) begin errors++; $display("[TB] FAIL en_out_on: out=%h expected 001", out); end
    write_reg(8'h01, 8'hFF);
    cycle();
    checks++; if (out !== 12'hF01) begin errors++; $display("[TB] FAIL en_out_high_byte: out=%h expected F01", out); end
    write_reg(8'h06, 8'hFF);
    write_reg(8'h1C, 8'h80);
    write_reg(8'h01, 8'h00);
    cycle();
    checks++; if (out !== 12'h001) begin errors++; $display("[TB] FAIL en_out_unmapped: out=%h expected 001", out); end
    repeat (6) begin
      cycle();
      checks++; if (out !== m_out[NUM_CH-1:0]) begin errors++; $display("[TB] FAIL en_out_track: out=%h expected %h", out, m_out[NUM_CH-1:0]); end
    end
  endtask

  task automatic test_edge_pwm();
    int cyc, highs, dis, ps;
    write_reg(8'h10, 8'h80);
    write_reg(8'h02, 8'h01);
    run_period(600, cyc, highs, dis, ps);
    checks++; if (ps != 1 || dis != 0) begin errors++; $display("[TB] FAIL edge_load: ps_seen=%0d disagreements=%0d expected 1/0", ps, dis); end
    repeat (2) begin
      run_period(600, cyc, highs, dis, ps);
      checks++; if (cyc != 256) begin errors++; $display("[TB] FAIL edge_period: cycles=%0d expected 256", cyc); end
      checks++; if (highs != 128) begin errors++; $display("[TB] FAIL edge_high: high cycles=%0d expected 128", highs); end
      checks++; if (dis != 0) begin errors++; $display("[TB] FAIL edge_model: disagreements=%0d expected 0", dis); end
    end
  endtask

  task automatic test_duty_extremes();
    int cyc, highs, dis, ps;
    write_reg(8'h10, 8'h00);
    run_period(600, cyc, highs, dis, ps);
    run_period(600, cyc, highs, dis, ps);
    checks++; if (highs != 0 || cyc != 256) begin errors++; $display("[TB] FAIL duty_zero: high=%0d cycles=%0d expected 0/256", highs, cyc); end
    write_reg(8'h10, 8'hFF);
    run_period(600, cyc, highs, dis, ps);
    run_period(600, cyc, highs, dis, ps);
    checks++; if (highs != 256 || cyc != 256) begin errors++; $display("[TB] FAIL duty_full: high=%0d cycles=%0d expected 256/256", highs, cyc); end
    checks++; if (dis != 0) begin errors++; $display("[TB] FAIL duty_extreme_model: disagreements=%0d expected 0", dis); end
  endtask

  task automatic test_deferred();
    int cyc, highs, dis, ps;
    bit hit;
    write_reg(8'h10, 8'h40);
    run_period(600, cyc, highs, dis, ps);
    cyc = 0; highs = 0;
    do begin
      bus_if.wr_en = (cyc == 100); bus_if.wr_addr = 8'h10; bus_if.wr_data = 8'hC0;
      cycle(); cyc++;
      if (out[0]) highs++;
    end while (period_start !== 1'b1 && cyc < 600);
    bus_if.wr_en = 1'b0;
    checks++; if (highs != 64 || cyc != 256) begin errors++; $display("[TB] FAIL midperiod_write: high=%0d cycles=%0d expected 64/256", highs, cyc); end
    cyc = 0; highs = 0; hit = 1'b0;
    do begin
      bus_if.wr_en = boundary_next(); bus_if.wr_addr = 8'h10; bus_if.wr_data = 8'h40;
      hit = bus_if.wr_en;
      cycle(); cyc++;
      if (out[0]) highs++;
    end while (!hit && cyc < 600);
    bus_if.wr_en = 1'b0;
    checks++; if (period_start !== 1'b1) begin errors++; $display("[TB] FAIL coincident_boundary: period_start=%b expected 1", period_start); end
    checks++; if (highs != 192) begin errors++; $display("[TB] FAIL new_duty_period: high=%0d expected 192", highs); end
    run_period(600, cyc, highs, dis, ps);
    checks++; if (highs != 192) begin errors++; $display("[TB] FAIL coincident_deferred: high=%0d expected 192", highs); end
    run_period(600, cyc, highs, dis, ps);
    checks++; if (highs != 64) begin errors++; $display("[TB] FAIL coincident_applied: high=%0d expected 64", highs); end
  endtask

  task automatic test_center();
    int cyc, highs, dis, ps, lead, trail;
    bit seen_low;
    write_reg(8'h04, 8'h01);
    write_reg(8'h05, 8'h01);
    write_reg(8'h10, 8'h80);
    run_period(600, cyc, highs, dis, ps);
    cyc = 0; highs = 0; dis = 0; lead = 0; trail = 0; seen_low = 1'b0;
    do begin
      cycle(); cyc++;
      if (out[0]) begin
        highs++;
        if (!seen_low) lead++; else trail++;
      end else begin
        seen_low = 1'b1;
        trail = 0;
      end
      if (out !== m_out[NUM_CH-1:0] || period_start !== m_ps) dis++;
    end while (period_start !== 1'b1 && cyc < 2000);
    checks++; if (cyc != 1020) begin errors++; $display("[TB] FAIL center_period: cycles=%0d expected 1020", cyc); end
    checks++; if (highs != 510) begin errors++; $display("[TB] FAIL center_high: high=%0d expected 510", highs); end
    checks++; if (lead != 256 || trail != 254) begin errors++; $display("[TB] FAIL center_symmetry: lead=%0d trail=%0d expected 256/254", lead, trail); end
    checks++; if (dis != 0) begin errors++; $display("[TB] FAIL center_model: disagreements=%0d expected 0", dis); end
  endtask

  task automatic test_random();
    logic [7:0] a, d;
    for (int k = 0; k < 4000; k++) begin
      bus_if.wr_en = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 7))
        0: a = 8'h00;
        1: a = 8'h01;
        2: a = 8'h02;
        3: a = 8'h03;
        4: a = 8'h04;
        5: a = 8'h05;
        6: a = 8'(8'h10 + $urandom_range(0, 15));
        default: a = 8'($urandom_range(0, 255));
      endcase
      d = 8'($urandom);
      if (a == 8'h04) d = 8'($urandom_range(0, 2));
      bus_if.wr_addr = a;
      bus_if.wr_data = d;
      cycle();
      checks++; if (out !== m_out[NUM_CH-1:0]) begin errors++; $display("[TB] FAIL random_out at %0d: out=%h expected %h", k, out, m_out[NUM_CH-1:0]); end
      checks++; if (period_start !== m_ps) begin errors++; $display("[TB] FAIL random_ps at %0d: period_start=%b expected %b", k, period_start, m_ps); end
    end
    bus_if.wr_en = 1'b0;
  endtask

  task automatic test_async_reset();
    int cyc, highs, dis, ps;
    write_reg(8'h02, 8'h00);
    write_reg(8'h03, 8'h00);
    write_reg(8'h00, 8'hFF);
    write_reg(8'h01, 8'h0F);
    cycle();
    checks++; if (out !== 12'hFFF) begin errors++; $display("[TB] FAIL pre_reset_high: out=%h expected FFF", out); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out !== 12'h000) begin errors++; $display("[TB] FAIL async_reset_out: out=%h expected 000", out); end
    checks++; if (period_start !== 1'b0) begin errors++; $display("[TB] FAIL async_reset_ps: period_start=%b expected 0", period_start); end
    model_reset();
    repeat (2) begin
      @(posedge clk); #1;
      checks++; if (out !== 12'h000) begin errors++; $display("[TB] FAIL reset_hold: out=%h expected 000", out); end
    end
    rst_n = 1'b1;
    run_period(600, cyc, highs, dis, ps);
    checks++; if (cyc != 256 || ps != 1) begin errors++; $display("[TB] FAIL restart_period: cycles=%0d ps_seen=%0d expected 256/1", cyc, ps); end
    checks++; if (highs != 0 || dis != 0) begin errors++; $display("[TB] FAIL restart_cleared: high=%0d disagreements=%0d expected 0/0", highs, dis); end
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_enable_out();
    test_edge_pwm();
    test_duty_extremes();
    test_deferred();
    test_center();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pwm_multichannel.md
PWM_MULTICHANNEL -- requirements
Module: pwm_multichannel

Interface
REQ-001 Parameter NUM_CH, default 16, sets the number of PWM channels; legal range is 1..16.
REQ-002 Parameter RES, default 8, sets the counter and duty resolution in bits; legal range is 2..8.
REQ-003 Port clk, input, 1 bit, is the single clock; every flop is clocked on its rising edge.
REQ-004 Port rst_n, input, 1 bit, is the reset; it is asynchronous and active-low.
REQ-005 Port wr_en, input, 1 bit, is a one-cycle register write strobe.
REQ-006 Port wr_addr, input, 8 bits, is the register address.
REQ-007 Port wr_data, input, 8 bits, is the write data.
REQ-008 Port out, output, NUM_CH bits, carries the channel outputs.
REQ-009 Port period_start, output, 1 bit, is a one-cycle pulse at each PWM period boundary.

Function
REQ-010 Register map (write-only): 0x00/0x01 en_out[7:0]/[15:8]; 0x02/0x03 en_pwm[7:0]/[15:8]; 0x04 prescale[7:0]; 0x05 mode (bit0: 0=edge, 1=center); 0x10+i duty_shadow[i] = wr_data[RES-1:0], for i<NUM_CH.
REQ-011 Writes to unmapped addresses, channel bits >= NUM_CH, and 0x10+i with i>=NUM_CH SHALL be ignored with no side effects.
REQ-012 A register written at rising edge N SHALL hold the new value from edge N onward; out SHALL be registered and reflect it at edge N+1.
REQ-013 Prescaler: presc_cnt counts 0..prescale_act and then wraps; tick is asserted when presc_cnt==prescale_act; prescale_act=0 gives a tick every cycle.
REQ-014 Edge mode: on each tick, cnt increments 0..2^RES-1 and wraps to 0; the wrap is the period boundary (period = 2^RES ticks).
REQ-015 Center mode: on each tick, cnt counts up to 2^RES-1, then down to 0, then up again; each endpoint is held for exactly one tick; the boundary is the tick where cnt returns to 0 (period = 2*(2^RES-1) ticks).
REQ-016 pwm_i SHALL be 1 when cnt < duty_act[i], except that duty_act[i] = all-ones SHALL force pwm_i to a constant 1 and duty_act[i] = 0 SHALL force it to a constant 0.
REQ-017 out[i] SHALL be 0 if en_out[i]=0, 1 if en_out[i]=1 and en_pwm[i]=0, and pwm_i otherwise.
REQ-018 duty_act, prescale_act and mode_act SHALL load from their shadow registers only at a period boundary, so there are no glitched periods; en_out and en_pwm take effect immediately per REQ-012.
REQ-019 A shadow write in the same cycle as a boundary SHALL NOT be loaded at that boundary; it loads at the next boundary.
REQ-020 A mode change loaded at a boundary SHALL restart cnt at 0 counting up.
REQ-021 period_start SHALL be high for exactly one clk cycle, the cycle after each boundary tick.
REQ-022 If multiple writes target the same address, the last one wins; one write per cycle is the maximum.

Reset
REQ-023 While rst_n=0, all registers, shadow and active values, presc_cnt and cnt SHALL be 0, out SHALL be all-zero, and period_start SHALL be 0, asynchronously.
REQ-024 After rst_n deasserts, counting SHALL begin on the first rising clk edge; reset asserted mid-period SHALL abort the period immediately, with no completion.

Verification
REQ-025 Reset, then write 0x00=0x01 -> out[0]=1 two edges after wr_en; all other out bits stay 0.
REQ-026 With RES=8, edge mode, prescale=0, en_out[0]=en_pwm[0]=1, duty0=0x80 -> out[0] high 128 and low 128 cycles per 256-cycle period; period_start pulses every 256 cycles.
REQ-027 Duty0 set to 0x00 and then to 0xFF -> out[0] constant 0, then constant 1, with no single-cycle pulses.
REQ-028 Change duty0 from 0x40 to 0xC0 mid-period -> the current period keeps 64 high cycles and the next period has 192; a write coincident with the boundary is deferred one period.
REQ-029 Center mode, prescale=1, duty0=0x80 -> period of 1020 clk cycles, with the high pulse centred on cnt=0.
REQ-030 Assert rst_n=0 mid-period with outputs high -> out=0 within the same cycle, with no clock required.
